// File: rtl/game_pkg.sv
// Shared definitions for the reaction-game pipeline: phase codes, counter widths
// and the 16-bit Galois LFSR step used for randomised delays.
package game_pkg;

  typedef enum logic [2:0] {
    PHASE_IDLE      = 3'd0,
    PHASE_COUNTDOWN = 3'd1,
    PHASE_GREEN     = 3'd2,
    PHASE_WARN      = 3'd3,
    PHASE_RED       = 3'd4
  } phase_t;

  localparam int unsigned ROUND_CNT_W = 8;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
  localparam logic [15:0] Lfsr16Poly = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ Lfsr16Poly) : (cur >> 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q_o
);

  localparam logic [15:0] InitVal = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= InitVal;
    end else begin
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/light_sequencer.sv
// Red/green light phase sequencer feeding game_logic. Each phase lasts a whole number
// of prescaler ticks; green length is randomised from the LFSR when green is entered.
module light_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned GREEN_MIN       = 8,
  parameter int unsigned GREEN_RAND_W    = 3,
  parameter int unsigned WARN_TICKS      = 2,
  parameter int unsigned RED_TICKS       = 6,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   halt_i,
  output logic                   red_o,
  output logic                   enable_o,
  output logic                   warn_o,
  output logic [2:0]             phase_o,
  output logic [ROUND_CNT_W-1:0] round_cnt_o
);

  localparam int unsigned GreenMax = GREEN_MIN + (32'd1 << GREEN_RAND_W) - 32'd1;
  localparam int unsigned GreenW   = $clog2(GreenMax + 1);
  localparam int unsigned MaxTicks = max_u(max_u(COUNTDOWN_TICKS, GreenMax),
                                           max_u(WARN_TICKS, RED_TICKS));
  localparam int unsigned TimerW   = $clog2(MaxTicks + 1);
  localparam int unsigned PreW     = $clog2(TICK_DIV);
  localparam logic [15:0] RandMask = 16'((32'd1 << GREEN_RAND_W) - 32'd1);

  phase_t                   state_q, state_d;
  logic [PreW-1:0]          pre_q, pre_d;
  logic [TimerW-1:0]        timer_q, timer_d;
  logic [GreenW-1:0]        green_len_q, green_len_d;
  logic [ROUND_CNT_W-1:0]   round_cnt_q, round_cnt_d;
  logic                     red_q, red_d, enable_q, enable_d, warn_q, warn_d;
  logic [15:0]              lfsr_q;
  logic                     tick, phase_done;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q_o   (lfsr_q)
  );

  assign tick = (32'(pre_q) == TICK_DIV - 32'd1);

  // A phase ends on the tick that brings its tick count to N.
  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      PHASE_COUNTDOWN: phase_done = (32'(timer_q) + 32'd1 == COUNTDOWN_TICKS);
      PHASE_GREEN:     phase_done = (32'(timer_q) + 32'd1 == 32'(green_len_q));
      PHASE_WARN:      phase_done = (32'(timer_q) + 32'd1 == WARN_TICKS);
      PHASE_RED:       phase_done = (32'(timer_q) + 32'd1 == RED_TICKS);
      default:         phase_done = 1'b0;
    endcase
    phase_done = phase_done & tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PHASE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_i) begin
      state_d = PHASE_IDLE;
    end else begin
      case (state_q)
        PHASE_IDLE:      if (start_i)    state_d = PHASE_COUNTDOWN;
        PHASE_COUNTDOWN: if (phase_done) state_d = PHASE_GREEN;
        PHASE_GREEN:     if (phase_done) state_d = PHASE_WARN;
        PHASE_WARN:      if (phase_done) state_d = PHASE_RED;
        PHASE_RED:       if (phase_done) state_d = PHASE_GREEN;
        default:                         state_d = PHASE_IDLE;
      endcase
    end
  end

  always_comb begin
    red_d    = 1'b0;
    enable_d = 1'b0;
    warn_d   = 1'b0;
    unique case (state_d)
      PHASE_COUNTDOWN: red_d = 1'b1;
      PHASE_GREEN:     enable_d = 1'b1;
      PHASE_WARN: begin
        enable_d = 1'b1;
        warn_d   = 1'b1;
      end
      PHASE_RED: begin
        red_d    = 1'b1;
        enable_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Timing counters restart on every state change and stay parked in IDLE.
  always_comb begin
    pre_d       = pre_q;
    timer_d     = timer_q;
    green_len_d = green_len_q;
    round_cnt_d = round_cnt_q;
    if ((state_d != state_q) || (state_q == PHASE_IDLE)) begin
      pre_d   = '0;
      timer_d = '0;
    end else if (tick) begin
      pre_d   = '0;
      timer_d = timer_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    if ((state_d == PHASE_GREEN) && (state_q != PHASE_GREEN)) begin
      green_len_d = GreenW'(GREEN_MIN + 32'(lfsr_q & RandMask));
    end
    if ((state_q == PHASE_IDLE) && (state_d == PHASE_COUNTDOWN)) begin
      round_cnt_d = '0;
    end else if ((state_q == PHASE_RED) && (state_d == PHASE_GREEN) && (round_cnt_q != '1)) begin
      round_cnt_d = round_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      timer_q     <= '0;
      green_len_q <= '0;
      round_cnt_q <= '0;
      red_q       <= 1'b0;
      enable_q    <= 1'b0;
      warn_q      <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      timer_q     <= timer_d;
      green_len_q <= green_len_d;
      round_cnt_q <= round_cnt_d;
      red_q       <= red_d;
      enable_q    <= enable_d;
      warn_q      <= warn_d;
    end
  end

  assign red_o       = red_q;
  assign enable_o    = enable_q;
  assign warn_o      = warn_q;
  assign phase_o     = state_q;
  assign round_cnt_o = round_cnt_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: directed vector table, timed phase measurements and
// randomised start/halt traffic against a remaining-cycles reference model.
module tb_light_sequencer;

  localparam int unsigned TD   = 4;
  localparam int unsigned CD   = 3;
  localparam int unsigned GMIN = 8;
  localparam int unsigned GRW  = 3;
  localparam int unsigned WT   = 2;
  localparam int unsigned RT   = 6;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk, rst_n, start, halt;
  logic       red, enable, warn;
  logic [2:0] phase;
  logic [7:0] round_cnt;

  int vectors = 0;
  int miscompares = 0;

  light_sequencer #(
    .TICK_DIV        (TD),
    .COUNTDOWN_TICKS (CD),
    .GREEN_MIN       (GMIN),
    .GREEN_RAND_W    (GRW),
    .WARN_TICKS      (WT),
    .RED_TICKS       (RT),
    .LFSR_SEED       (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .halt_i      (halt),
    .red_o       (red),
    .enable_o    (enable),
    .warn_o      (warn),
    .phase_o     (phase),
    .round_cnt_o (round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase plus cycles remaining in it.
  int         m_phase, m_rem, m_glen, m_total;
  logic [7:0] m_round;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [2:0] lamps(input int p);
    case (p)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b011;
      4:       return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_rem   = 0;
    m_round = 8'd0;
    m_lfsr  = SEED;
  endtask

  task automatic enter_green(input logic [15:0] cur);
    logic [GRW-1:0] r;
    r       = cur[GRW-1:0];
    m_phase = 2;
    m_glen  = int'(TD) * (int'(GMIN) + int'(r));
    m_rem   = m_glen;
  endtask

  task automatic model_edge(input logic s, input logic h);
    logic [15:0] cur;
    cur = m_lfsr;
    if (h) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_rem   = int'(CD * TD);
        m_round = 8'd0;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_phase)
          1: enter_green(cur);
          2: begin m_phase = 3; m_rem = int'(WT * TD); end
          3: begin m_phase = 4; m_rem = int'(RT * TD); end
          default: begin
            m_total++;
            if (m_round != 8'd255) m_round = m_round + 8'd1;
            enter_green(cur);
          end
        endcase
      end
    end
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [2:0] l;
    l = lamps(m_phase);
    vectors++;
    if (int'(phase) != m_phase || {red, enable, warn} !== l || round_cnt !== m_round ||
        dut.u_lfsr.q_o !== m_lfsr || dut.u_lfsr.q_o == 16'h0) begin
      miscompares++;
      $display("FAIL model t=%0t phase %0d want %0d, lamps %b want %b, round %0d want %0d, lfsr %h want %h",
               $time, phase, m_phase, {red, enable, warn}, l, round_cnt, m_round,
               dut.u_lfsr.q_o, m_lfsr);
    end
  endtask

  task automatic step(input logic s, input logic h);
    start = s;
    halt  = h;
    @(posedge clk);
    model_edge(s, h);
    #1;
    check_model();
  endtask

  task automatic wait_phase(input int p, input int limit);
    int n;
    n = 0;
    while (int'(phase) != p && n < limit) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    check($sformatf("wait_phase%0d", p), int'(phase), p);
  endtask

  // Current phase p was entered on the last edge; count cycles until it is left.
  task automatic measure(input int p, input int exp, input string name);
    int n;
    n = 1;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'b0);
      if (int'(phase) != p) break;
      n++;
    end
    check(name, n, exp);
  endtask

  typedef struct {
    logic       s;
    logic       h;
    int         cycles;
    logic [2:0] ph;
    logic [2:0] lmp;
    logic [7:0] rnd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    tbl[0] = '{1'b0, 1'b0, 2,  3'd0, 3'b000, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 1,  3'd1, 3'b100, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 11, 3'd1, 3'b100, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1,  3'd2, 3'b010, 8'd0};
    tbl[4] = '{1'b1, 1'b0, 5,  3'd2, 3'b010, 8'd0};
    tbl[5] = '{1'b1, 1'b1, 1,  3'd0, 3'b000, 8'd0};
    tbl[6] = '{1'b0, 1'b0, 3,  3'd0, 3'b000, 8'd0};
    tbl[7] = '{1'b1, 1'b0, 1,  3'd1, 3'b100, 8'd0};
    tbl[8] = '{1'b0, 1'b0, 11, 3'd1, 3'b100, 8'd0};
    tbl[9] = '{1'b0, 1'b0, 1,  3'd2, 3'b010, 8'd0};

    rst_n = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset phase", int'(phase), 0);
    check("reset lamps", int'({red, enable, warn}), 0);
    check("reset round", int'(round_cnt), 0);
    check("reset lfsr", int'(dut.u_lfsr.q_o), int'(SEED));

    // Countdown length, start ignored outside IDLE, halt beats start.
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        step(tbl[i].s, tbl[i].h);
        vectors++;
        if (phase !== tbl[i].ph || {red, enable, warn} !== tbl[i].lmp || round_cnt !== tbl[i].rnd) begin
          miscompares++;
          $display("FAIL tbl[%0d] cyc %0d: phase %0d lamps %b round %0d, want %0d %b %0d",
                   i, c, phase, {red, enable, warn}, round_cnt, tbl[i].ph, tbl[i].lmp, tbl[i].rnd);
        end
      end
    end

    // Full green/warn/red cycle durations.
    g = m_glen;
    measure(2, g, "green length");
    measure(3, int'(WT * TD), "warn length");
    measure(4, int'(RT * TD), "red length");
    check("round after first red", int'(round_cnt), 1);

    // Halt with start in GREEN: round count held, then cleared by a new start.
    step(1'b1, 1'b1);
    check("halt phase", int'(phase), 0);
    check("halt enable", int'(enable), 0);
    check("halt round held", int'(round_cnt), 1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("restart phase", int'(phase), 1);
    check("restart round", int'(round_cnt), 0);

    // Random start pulses while running must not disturb timing.
    for (int i = 0; i < 800; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset in the middle of RED.
    wait_phase(4, 400);
    repeat (3) step(1'($urandom_range(0, 1)), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst lamps", int'({red, enable, warn}), 0);
    check("async rst phase", int'(phase), 0);
    check("async rst round", int'(round_cnt), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst lfsr", int'(dut.u_lfsr.q_o), int'(SEED));
    check("post-rst phase", int'(phase), 0);
    step(1'b1, 1'b0);
    wait_phase(2, 100);
    g = m_glen;
    measure(2, g, "green length after reset");

    // Mixed start/halt traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 47) == 0));
    end

    // Long run: round counter saturates and holds.
    m_total = 0;
    for (int i = 0; i < 40000 && m_total < 300; i++) step(1'b1, 1'b0);
    check("cycles completed", (m_total >= 300) ? 1 : 0, 1);
    check("round saturated", int'(round_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
